// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register bank: register map, ID value,
// CTRL/STATUS bit positions and the transaction FSM states.
package spi_regs_pkg;

   localparam int unsigned ADDR_ID      = 0;
   localparam int unsigned ADDR_CTRL    = 1;
   localparam int unsigned ADDR_GAIN    = 2;
   localparam int unsigned ADDR_STATUS  = 3;
   localparam int unsigned ADDR_LEVEL   = 4;
   localparam int unsigned ADDR_DATA    = 5;
   localparam int unsigned ADDR_SCRATCH = 6;

   localparam logic [7:0] ID_VALUE = 8'hA5;

   localparam int CTRL_AUDIO_EN_BIT = 0;
   localparam int CTRL_FLUSH_BIT    = 1;

   localparam int STATUS_EMPTY_BIT = 0;
   localparam int STATUS_FULL_BIT  = 1;
   localparam int STATUS_OVF_BIT   = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DECODE  = 3'd1,
      RD_HOLD = 3'd2,
      WR_WAIT = 3'd3,
      DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Power-of-two sample FIFO with synchronous flush; level saturates at DEPTH
// because pushes into a full FIFO are refused unless a pop frees a slot.
module sample_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [DW-1:0]           din,
   output logic [DW-1:0]           dout,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    full,
   output logic                    empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign level = count_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !flush && (!full || pop);
      do_pop   = pop && !flush && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
         else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-target register bank with a per-transaction FSM. Define SPI_REGS_FIFO_EN
// to compile in the audio sample FIFO together with STATUS, LEVEL and DATA.
module spi_reg_bank
   import spi_regs_pkg::*;
#(
   parameter int ADDRSZ     = 7,
   parameter int DW         = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDRSZ-1:0] reg_addr,
   input  logic              addr_dv,
   input  logic [DW-1:0]     rx_d,
   input  logic              rxdv,
   input  logic              rw_out,
   output logic [DW-1:0]     tx_d,
   output logic              tx_en,
   input  logic [DW-1:0]     sample_data,
   input  logic              sample_valid,
   output logic              audio_en,
   output logic [DW-1:0]     gain
);

   state_e              state_q, state_d;
   logic                addr_dv_q, addr_dv_d;
   logic                rxdv_q, rxdv_d;
   logic [ADDRSZ-1:0]   addr_lat_q, addr_lat_d;
   logic                rw_lat_q, rw_lat_d;
   logic [DW-1:0]       tx_d_q, tx_d_d;
   logic                tx_en_q, tx_en_d;
   logic                wr_pend_q, wr_pend_d;
   logic [DW-1:0]       wr_data_q, wr_data_d;
   logic                audio_en_q, audio_en_d;
   logic [DW-1:0]       gain_q, gain_d;
   logic [DW-1:0]       scratch_q, scratch_d;
   logic [DW-1:0]       rd_data;
   logic                rd_fire, wr_commit, flush_req;

   assign tx_d     = tx_d_q;
   assign tx_en    = tx_en_q;
   assign audio_en = audio_en_q;
   assign gain     = gain_q;

`ifdef SPI_REGS_FIFO_EN
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   logic [LW-1:0] fifo_level;
   logic [DW-1:0] fifo_dout, status;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic          flush_q, flush_d, ovf_q, ovf_d;

   sample_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset_n(reset_n), .push(fifo_push), .pop(fifo_pop),
      .flush(flush_q), .din(sample_data), .dout(fifo_dout),
      .level(fifo_level), .full(fifo_full), .empty(fifo_empty)
   );

   // Overflow set wins over a same-cycle clear; a flush drops any push.
   always_comb begin
      fifo_push = sample_valid && audio_en_q;
      fifo_pop  = rd_fire && (addr_lat_q == ADDRSZ'(ADDR_DATA)) && !fifo_empty;
      flush_d   = flush_req;
      ovf_d     = ovf_q;
      if (flush_q || (rd_fire && addr_lat_q == ADDRSZ'(ADDR_STATUS))) ovf_d = 1'b0;
      if (fifo_push && fifo_full && !fifo_pop && !flush_q) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flush_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         flush_q <= flush_d;
         ovf_q   <= ovf_d;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = (^{sample_data, sample_valid, flush_req}) ^ (FIFO_DEPTH > 0);
`endif

   always_comb begin
      rd_data = '0;
`ifdef SPI_REGS_FIFO_EN
      status = '0;
      status[STATUS_EMPTY_BIT] = fifo_empty;
      status[STATUS_FULL_BIT]  = fifo_full;
      status[STATUS_OVF_BIT]   = ovf_q;
`endif
      case (addr_lat_q)
         ADDRSZ'(ADDR_ID):      rd_data = DW'(ID_VALUE);
         ADDRSZ'(ADDR_CTRL):    rd_data[CTRL_AUDIO_EN_BIT] = audio_en_q;
         ADDRSZ'(ADDR_GAIN):    rd_data = gain_q;
         ADDRSZ'(ADDR_SCRATCH): rd_data = scratch_q;
`ifdef SPI_REGS_FIFO_EN
         ADDRSZ'(ADDR_STATUS):  rd_data = status;
         ADDRSZ'(ADDR_LEVEL):   rd_data = DW'(fifo_level);
         ADDRSZ'(ADDR_DATA):    rd_data = fifo_empty ? '0 : fifo_dout;
`endif
         default:               rd_data = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      addr_dv_d  = addr_dv;
      rxdv_d     = rxdv;
      addr_lat_d = addr_lat_q;
      rw_lat_d   = rw_lat_q;
      tx_d_d     = tx_d_q;
      tx_en_d    = tx_en_q;
      wr_pend_d  = wr_pend_q;
      wr_data_d  = wr_data_q;
      rd_fire    = 1'b0;
      wr_commit  = 1'b0;
      case (state_q)
         IDLE: begin
            tx_en_d   = 1'b0;
            wr_pend_d = 1'b0;
            if (addr_dv && !addr_dv_q) begin
               state_d    = DECODE;
               addr_lat_d = reg_addr;
               rw_lat_d   = rw_out;
            end
         end
         DECODE: begin
            if (rw_lat_q) begin
               state_d = RD_HOLD;
               tx_d_d  = rd_data;
               tx_en_d = 1'b1;
               rd_fire = 1'b1;
            end else begin
               state_d = WR_WAIT;
            end
         end
         RD_HOLD: ;
         WR_WAIT: begin
            if (rxdv && !rxdv_q) begin
               state_d   = DONE;
               wr_pend_d = 1'b1;
               wr_data_d = rx_d;
            end
         end
         DONE: begin
            if (wr_pend_q) begin
               wr_commit = 1'b1;
               wr_pend_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      // Losing addr_dv aborts everything, including an uncommitted write.
      if (state_q != IDLE && !addr_dv) begin
         state_d   = IDLE;
         tx_en_d   = 1'b0;
         wr_pend_d = 1'b0;
         rd_fire   = 1'b0;
         wr_commit = 1'b0;
      end
   end

   always_comb begin
      audio_en_d = audio_en_q;
      gain_d     = gain_q;
      scratch_d  = scratch_q;
      flush_req  = 1'b0;
      if (wr_commit) begin
         case (addr_lat_q)
            ADDRSZ'(ADDR_CTRL): begin
               audio_en_d = wr_data_q[CTRL_AUDIO_EN_BIT];
               flush_req  = wr_data_q[CTRL_FLUSH_BIT];
            end
            ADDRSZ'(ADDR_GAIN):    gain_d    = wr_data_q;
            ADDRSZ'(ADDR_SCRATCH): scratch_d = wr_data_q;
            default: ;
         endcase
      end
   end

   // addr_dv_q resets high so a level already high at reset release is not
   // mistaken for the start of a new transaction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         addr_dv_q  <= 1'b1;
         rxdv_q     <= 1'b0;
         addr_lat_q <= '0;
         rw_lat_q   <= 1'b0;
         tx_d_q     <= '0;
         tx_en_q    <= 1'b0;
         wr_pend_q  <= 1'b0;
         wr_data_q  <= '0;
         audio_en_q <= 1'b0;
         gain_q     <= '0;
         scratch_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_dv_q  <= addr_dv_d;
         rxdv_q     <= rxdv_d;
         addr_lat_q <= addr_lat_d;
         rw_lat_q   <= rw_lat_d;
         tx_d_q     <= tx_d_d;
         tx_en_q    <= tx_en_d;
         wr_pend_q  <= wr_pend_d;
         wr_data_q  <= wr_data_d;
         audio_en_q <= audio_en_d;
         gain_q     <= gain_d;
         scratch_q  <= scratch_d;
      end
   end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: read responses go through an expected
// queue checked by a monitor on each tx_en rising edge.
module tb_spi_reg_bank;
   import spi_regs_pkg::*;

   localparam int ADDRSZ     = 7;
   localparam int DW         = 8;
   localparam int FIFO_DEPTH = 16;
`ifdef SPI_REGS_FIFO_EN
   localparam bit FIFO_EN = 1'b1;
`else
   localparam bit FIFO_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [ADDRSZ-1:0] reg_addr = '0;
   logic              addr_dv = 1'b0;
   logic [DW-1:0]     rx_d = '0;
   logic              rxdv = 1'b0;
   logic              rw_out = 1'b0;
   logic [DW-1:0]     tx_d;
   logic              tx_en;
   logic [DW-1:0]     sample_data = '0;
   logic              sample_valid = 1'b0;
   logic              audio_en;
   logic [DW-1:0]     gain;

   logic [DW-1:0] exp_q[$];
   int            total = 0;
   int            bad = 0;
   logic          tx_en_prev = 1'b0;

   spi_reg_bank #(.ADDRSZ(ADDRSZ), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .reg_addr(reg_addr), .addr_dv(addr_dv),
      .rx_d(rx_d), .rxdv(rxdv), .rw_out(rw_out), .tx_d(tx_d), .tx_en(tx_en),
      .sample_data(sample_data), .sample_valid(sample_valid),
      .audio_en(audio_en), .gain(gain)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] fx(input logic [7:0] v);
      return FIFO_EN ? v : 8'h00;
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      if (tx_en === 1'b1 && tx_en_prev !== 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got 0x%0h want no read", tx_d);
         end else begin
            check("rd_data", tx_d, exp_q.pop_front());
         end
      end
      tx_en_prev = tx_en;
   end

   // driver tasks; all start and end on a falling clock edge
   task automatic rd_begin(input logic [6:0] a, input logic [7:0] e);
      int n;
      exp_q.push_back(e);
      reg_addr = a;
      rw_out   = 1'b1;
      addr_dv  = 1'b1;
      n = 0;
      while (tx_en !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("rd_latency", n, 2);
   endtask

   task automatic host_read(input logic [6:0] a, input logic [7:0] e);
      rd_begin(a, e);
      repeat (2) @(negedge clk);
      check("rd_hold_en", tx_en, 1);
      check("rd_hold_data", tx_d, e);
      addr_dv = 1'b0;
      @(negedge clk);
      check("rd_release", tx_en, 0);
      @(negedge clk);
   endtask

   task automatic wr_start(input logic [6:0] a, input logic [7:0] d);
      reg_addr = a;
      rw_out   = 1'b0;
      rx_d     = d;
      addr_dv  = 1'b1;
      repeat (2) @(negedge clk);
      rxdv = 1'b1;
   endtask

   task automatic txn_end();
      rxdv    = 1'b0;
      addr_dv = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic host_write(input logic [6:0] a, input logic [7:0] d);
      wr_start(a, d);
      repeat (3) @(negedge clk);
      txn_end();
   endtask

   task automatic push(input logic [7:0] d);
      sample_data  = d;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_tx_en", tx_en, 0);
      check("rst_tx_d", tx_d, 0);
      check("rst_gain", gain, 0);
      check("rst_audio_en", audio_en, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_fsm", 32'(dut.state_q), 32'(IDLE));

      // ID and unmapped reads
      host_read(7'h00, 8'hA5);
      host_read(7'h07, 8'h00);
      host_read(7'h40, 8'h00);

      // GAIN write: lands two cycles after rxdv rises; later edges ignored
      wr_start(7'h02, 8'h3C);
      @(negedge clk);
      check("gain_early", gain, 8'h00);
      @(negedge clk);
      check("gain_write", gain, 8'h3C);
      rxdv = 1'b0;
      @(negedge clk);
      rx_d = 8'h77;
      rxdv = 1'b1;
      repeat (3) @(negedge clk);
      check("gain_second_edge", gain, 8'h3C);
      txn_end();
      host_read(7'h02, 8'h3C);

      // aborted writes to SCRATCH: before rxdv, and after rxdv but before commit
      reg_addr = 7'h06;
      rw_out   = 1'b0;
      rx_d     = 8'h99;
      addr_dv  = 1'b1;
      repeat (3) @(negedge clk);
      addr_dv = 1'b0;
      @(negedge clk);
      check("abort_fsm", 32'(dut.state_q), 32'(IDLE));
      rxdv = 1'b1;
      repeat (2) @(negedge clk);
      rxdv = 1'b0;
      @(negedge clk);
      wr_start(7'h06, 8'h5A);
      @(negedge clk);
      addr_dv = 1'b0;
      rxdv    = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_pend_fsm", 32'(dut.state_q), 32'(IDLE));
      host_read(7'h06, 8'h00);
      host_write(7'h06, 8'h5A);
      host_read(7'h06, 8'h5A);
      host_write(7'h10, 8'hFF);
      host_read(7'h10, 8'h00);
      host_write(7'h00, 8'h12);
      host_read(7'h00, 8'hA5);

      // FIFO fill and drain
      host_write(7'h01, 8'h01);
      check("audio_en_on", audio_en, 1);
      push(8'h11);
      push(8'h22);
      push(8'h33);
      host_read(7'h04, fx(8'h03));
      host_read(7'h05, fx(8'h11));
      host_read(7'h05, fx(8'h22));
      host_read(7'h05, fx(8'h33));
      host_read(7'h05, 8'h00);
      host_read(7'h04, 8'h00);
      host_read(7'h03, fx(8'h01));

      // overflow: 17 pushes into depth 16
      for (int i = 1; i <= 17; i++) begin
         sample_data  = 8'(i);
         sample_valid = 1'b1;
         @(negedge clk);
      end
      sample_valid = 1'b0;
      host_read(7'h03, fx(8'h06));
      host_read(7'h03, fx(8'h02));
      host_read(7'h04, fx(8'h10));
      host_read(7'h05, fx(8'h01));
      host_read(7'h03, 8'h00);
      host_read(7'h04, fx(8'h0F));

      // flush via CTRL bit1; flush bit reads back 0
      host_write(7'h01, 8'h03);
      host_read(7'h01, 8'h01);
      host_read(7'h03, fx(8'h01));
      host_read(7'h04, 8'h00);
      push(8'h44);
      host_read(7'h05, fx(8'h44));

      // audio disabled: samples ignored
      host_write(7'h01, 8'h00);
      check("audio_en_off", audio_en, 0);
      push(8'h55);
      host_read(7'h04, 8'h00);

      // reset in the middle of a read
      rd_begin(7'h02, 8'h3C);
      reset_n = 1'b0;
      #1;
      check("midrst_tx_en", tx_en, 0);
      check("midrst_tx_d", tx_d, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst_no_restart", tx_en, 0);
      check("midrst_fsm", 32'(dut.state_q), 32'(IDLE));
      check("midrst_gain", gain, 8'h00);
      addr_dv = 1'b0;
      repeat (2) @(negedge clk);
      host_read(7'h02, 8'h00);

      // final report
      repeat (4) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL exp_q_drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameters: ADDRSZ, default 7, SPI register address width; DW, default 8, data width; FIFO_DEPTH, default 16, power-of-two sample FIFO depth.
REQ-002 SHALL have ports, in this order:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- reg_addr  in  ADDRSZ  register address from the SPI target.
- addr_dv  in  1  address valid; high for the remainder of the transaction.
- rx_d  in  DW  write data from the SPI target.
- rxdv  in  1  write data valid.
- rw_out  in  1  1 = host read, 0 = host write.
- tx_d  out  DW  read data to the SPI target.
- tx_en  out  1  read data enable; its rising edge loads tx_d.
- sample_data  in  DW  audio sample.
- sample_valid  in  1  single-cycle sample strobe.
- audio_en  out  1  CTRL[0].
- gain  out  DW  GAIN register.

Function
REQ-003 SHALL implement this register map; unmapped addresses read 0x00 and ignore writes:
- 0x00 ID, read-only, 0xA5.
- 0x01 CTRL, read/write; bit0 audio_en; bit1 flush, self-clearing, always reads 0.
- 0x02 GAIN, read/write.
- 0x03 STATUS, read-only; bit0 empty, bit1 full, bit2 overflow (sticky, cleared by reading STATUS).
- 0x04 LEVEL, read-only, FIFO occupancy.
- 0x05 DATA, read-only; a read pops one entry.
- 0x06 SCRATCH, read/write.
REQ-004 SHALL use an FSM with states IDLE, DECODE, RD_HOLD, WR_WAIT and DONE.
REQ-005 IDLE -> DECODE on the rising edge of addr_dv; reg_addr and rw_out SHALL be latched in that same cycle.
REQ-006 DECODE SHALL go to RD_HOLD when the latched rw is 1, otherwise to WR_WAIT; the transition takes one cycle.
REQ-007 On entry to RD_HOLD, tx_d SHALL be loaded from the register mux and tx_en asserted in the next cycle; both SHALL stay stable until addr_dv falls.
REQ-008 Read side effects (DATA pop, overflow clear) SHALL occur exactly once per transaction, in the cycle tx_en rises.
REQ-009 A read of DATA while the FIFO is empty SHALL return 0x00 with no pop and no level change.
REQ-010 WR_WAIT: the first rxdv rising edge SHALL write rx_d to the latched address in the following cycle, then go to DONE; later rxdv edges in the same transaction SHALL be ignored.
REQ-011 A fall of addr_dv in any non-IDLE state SHALL return the FSM to IDLE in the next cycle with tx_en low; a write that has not yet committed SHALL be discarded.
REQ-012 FIFO push: occurs on sample_valid while audio_en=1.
REQ-013 A push into a full FIFO SHALL be dropped and SHALL set overflow.
REQ-014 A simultaneous push and pop SHALL leave the level unchanged.
REQ-015 Overflow set and overflow clear in the same cycle SHALL leave overflow set.
REQ-016 A write of CTRL with bit1=1 SHALL empty the FIFO one cycle later and clear overflow; a push in that same cycle SHALL be discarded.
REQ-017 LEVEL SHALL saturate at FIFO_DEPTH; the pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-018 SHALL reset asynchronously on reset_n low to:
- FSM IDLE;
- tx_d=0, tx_en=0;
- audio_en=0, gain=0x00;
- SCRATCH=0x00, CTRL=0x00;
- FIFO empty, overflow=0.
REQ-019 A reset mid-transaction SHALL abort it; after release the FSM SHALL wait for a fresh addr_dv rising edge.

Configuration
REQ-020 Macro SPI_REGS_FIFO_EN, when defined, SHALL compile in the sample FIFO, STATUS, LEVEL and DATA.
REQ-021 When SPI_REGS_FIFO_EN is undefined, addresses 0x03-0x05 SHALL read 0x00, sample inputs SHALL be ignored, and CTRL bit1 SHALL have no effect.

Structure
REQ-022 Package spi_regs_pkg SHALL hold the register address localparams, ID_VALUE=0xA5, the CTRL/STATUS bit indices and the FSM state enum.
REQ-023 The FIFO SHALL be a sub-module named sample_fifo, with ports push, pop, flush, din, dout, level, full and empty.

Verification
REQ-024 Write GAIN: host write addr 0x02 data 0x3C -> gain=0x3C two cycles after rxdv rises; a later read of 0x02 returns tx_d=0x3C.
REQ-025 ID read: host read addr 0x00 -> tx_en rises two cycles after addr_dv rises with tx_d=0xA5, held until addr_dv falls.
REQ-026 FIFO fill and drain: audio_en=1, push 0x11,0x22,0x33 -> LEVEL reads 3; three DATA reads return 0x11,0x22,0x33; a fourth DATA read returns 0x00 and LEVEL stays 0.
REQ-027 Overflow: push 17 samples into depth 16 -> STATUS reads 0x06; the next STATUS read returns 0x02.
REQ-028 Aborted write: addr 0x06 write, addr_dv drops before rxdv -> SCRATCH unchanged at 0x00, FSM in IDLE.
REQ-029 Reset mid-read: reset_n pulsed while in RD_HOLD -> tx_en=0 immediately; the following read of 0x02 returns 0x00.
